mem_arb: RTL

Single-port memory arbiter and sequencer that lets the core's instruction-fetch port and its load/store port share one synchronous single-port RAM. It sits between the core and the RAM macro, grants at most one access per cycle with round-robin fairness, and formats data for RISC-V load/store widths. It generates the RAM byte enables, and aligns and sign-extends returned load data.

---
 rtl/mem_arb.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mem_arb.sv
// mem_arb: round-robin arbiter sharing one single-port RAM between
// instruction fetch and load/store, with byte-lane and load formatting.
module mem_arb #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [2:0]    d_op,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_err,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [3:0]    mem_be,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   logic          r_prio;
   logic          r_pend_v;
   logic          r_pend_own;
   logic [2:0]    r_pend_op;
   logic [1:0]    r_pend_off;

   logic          w_if_win;
   logic          w_d_win;
   logic          w_d_acc;
   logic          w_isb;
   logic          w_ish;
   logic          w_isw;
   logic          w_mis;
   logic [1:0]    w_off;
   logic [DW-1:0] w_sh;
   logic [DW-1:0] w_fmt;

   // d_op[1:0] alone classifies width; 011/110/111 fall into word
   assign w_off = d_addr[1:0];
   assign w_isb = (d_op[1:0] == 2'b00);
   assign w_ish = (d_op[1:0] == 2'b01);
   assign w_isw = ~w_isb & ~w_ish;
   assign w_mis = (w_ish & w_off[0]) | (w_isw & (|w_off));

   assign w_if_win = rst & if_req & (~d_req | ~r_prio);
   assign w_d_win  = rst & d_req & (~if_req | r_prio);
   assign w_d_acc  = w_d_win & ~w_mis;

   assign if_gnt = w_if_win;
   assign d_gnt  = w_d_win;
   assign d_err  = w_d_win & w_mis;

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_be    = 4'b0000;
      mem_addr  = '0;
      mem_wdata = '0;
      if (w_if_win) begin
         mem_en   = 1'b1;
         mem_be   = 4'b1111;
         mem_addr = if_addr & ~AW'(3);
      end else if (w_d_acc) begin
         mem_en   = 1'b1;
         mem_we   = d_we;
         mem_addr = d_addr & ~AW'(3);
         if (!d_we) begin
            mem_be = 4'b1111;
         end else begin
            unique case (1'b1)
               w_isb: begin
                  mem_be    = 4'b0001 << w_off;
                  mem_wdata = {4{d_wdata[7:0]}};
               end
               w_ish: begin
                  mem_be    = 4'b0011 << w_off;
                  mem_wdata = {2{d_wdata[15:0]}};
               end
               w_isw: begin
                  mem_be    = 4'b1111;
                  mem_wdata = d_wdata;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_prio     <= 1'b1;
         r_pend_v   <= 1'b0;
         r_pend_own <= 1'b0;
         r_pend_op  <= 3'b000;
         r_pend_off <= 2'b00;
      end else begin
         if (w_if_win | w_d_win)
            r_prio <= w_if_win;
         r_pend_v   <= mem_en & ~mem_we;
         r_pend_own <= w_d_acc;
         r_pend_op  <= d_op;
         r_pend_off <= d_addr[1:0];
      end
   end

   assign w_sh = mem_rdata >> {r_pend_off, 3'b000};

   always_comb begin
      case (r_pend_op[1:0])
         2'b00:   w_fmt = {{24{~r_pend_op[2] & w_sh[7]}}, w_sh[7:0]};
         2'b01:   w_fmt = {{16{~r_pend_op[2] & w_sh[15]}}, w_sh[15:0]};
         default: w_fmt = mem_rdata;
      endcase
   end

   assign if_rvalid = r_pend_v & ~r_pend_own;
   assign d_rvalid  = r_pend_v & r_pend_own;
   assign if_rdata  = if_rvalid ? mem_rdata : '0;
   assign d_rdata   = d_rvalid ? w_fmt : '0;

endmodule
